ts_packet_gen_mc: RTL and testbench

Multi-channel MPEG-TS packet generator; parametrised successor of the single-stream ts_packet_gen. It builds fixed-length TS packets for up to N_CH logical channels, each with its own PID and 4-bit continuity counter. Channels are served round-robin onto one byte stream with a ready/valid handshake, so the Ethernet/UDP framer downstream can apply backpressure. It runs in the 125 MHz datapath domain, upstream of the packet framer.

---
 rtl/ts_pkg.sv | 17 +
 rtl/ts_packet_gen_mc_if.sv | 11 +
 rtl/ts_packet_gen_mc_rr_arbiter.sv | 25 ++
 rtl/ts_packet_gen_mc.sv | 104 ++++++++++
 tb/tb_ts_packet_gen_mc.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/ts_pkg.sv
// ts_pkg: shared TS constants, FSM state type and packet byte builder
package ts_pkg;
  localparam logic [7:0] TS_SYNC_BYTE = 8'h47;
  localparam logic [7:0] TS_NULL_BYTE = 8'hFF;
  localparam int TS_PID_W = 13;
  localparam int TS_CC_W = 4;
  typedef enum logic [1:0] {IDLE, ARB, SEND, GAP} ts_state_e;
  // Header bytes 0..3, then counting or null payload.
  function automatic logic [7:0] ts_byte(input logic [15:0] i, input logic [TS_PID_W-1:0] p,
                                         input logic [TS_CC_W-1:0] cc, input logic null_mode);
    return i == 16'd0 ? TS_SYNC_BYTE :
           i == 16'd1 ? {3'b010, p[12:8]} :
           i == 16'd2 ? p[7:0] :
           i == 16'd3 ? {4'b0001, cc} :
           null_mode ? TS_NULL_BYTE : i[7:0] - 8'd4;
  endfunction
endpackage

// File: rtl/ts_packet_gen_mc_if.sv
// ts_packet_gen_mc_if: TS byte stream with ready/valid backpressure
interface ts_packet_gen_mc_if #(parameter int CH_W = 2) ();
  logic [7:0] ts_data;
  logic ts_valid;
  logic ts_ready;
  logic ts_start;
  logic ts_end;
  logic [CH_W-1:0] ts_ch;
  modport master(output ts_data, ts_valid, ts_start, ts_end, ts_ch, input ts_ready);
  modport slave(input ts_data, ts_valid, ts_start, ts_end, ts_ch, output ts_ready);
endinterface

// File: rtl/ts_packet_gen_mc_rr_arbiter.sv
// rr_arbiter: picks first requesting channel strictly after the last grant, cyclic
module rr_arbiter #(
  parameter int N_CH = 4,
  parameter int CH_W = 2
) (
  input  logic [N_CH-1:0] req,
  input  logic [CH_W-1:0] last,
  output logic            gnt_vld,
  output logic [CH_W-1:0] gnt_idx
);
  logic [CH_W-1:0] c;
  // Scan from farthest to nearest so the nearest requester after last wins.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    c = '0;
    for (int k = N_CH; k >= 1; k--) begin
      c = CH_W'((int'(last) + k) % N_CH);
      if (req[c]) begin
        gnt_vld = 1'b1;
        gnt_idx = c;
      end
    end
  end
endmodule

// File: rtl/ts_packet_gen_mc.sv
// ts_packet_gen_mc: round-robin multi-channel MPEG-TS packet generator
module ts_packet_gen_mc
  import ts_pkg::*;
#(
  parameter int N_CH = 4,
  parameter int PKT_LEN = 188,
  parameter int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable,
  input  logic [N_CH-1:0]          ch_enable,
  input  logic [TS_PID_W*N_CH-1:0] pid,
  input  logic [15:0]              gap,
  input  logic                     payload_mode,
  ts_packet_gen_mc_if.master       ts,
  output logic [31:0]              pkt_count
);
  localparam int IDX_W = $clog2(PKT_LEN);
  ts_state_e state;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] nidx;
  logic [CH_W-1:0] ptr;
  logic [CH_W-1:0] cur_ch;
  logic [CH_W-1:0] gnt_idx;
  logic gnt_vld;
  logic [TS_PID_W-1:0] cur_pid;
  logic [TS_CC_W-1:0] cur_cc;
  logic cur_mode;
  logic [15:0] gap_cnt;
  logic [TS_CC_W-1:0] cc [N_CH];
  logic last_byte;
  assign nidx = idx + 1'b1;
  assign last_byte = idx == IDX_W'(PKT_LEN - 1);
  assign ts.ts_ch = cur_ch;
  rr_arbiter #(.N_CH(N_CH), .CH_W(CH_W)) u_arb (
    .req    (ch_enable),
    .last   (ptr),
    .gnt_vld(gnt_vld),
    .gnt_idx(gnt_idx)
  );
  // Packet FSM: arbitrate, stream bytes under backpressure, then idle for the latched gap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      idx <= '0;
      ptr <= CH_W'(N_CH - 1);
      cur_ch <= '0;
      cur_pid <= '0;
      cur_cc <= '0;
      cur_mode <= 1'b0;
      gap_cnt <= '0;
      pkt_count <= '0;
      ts.ts_valid <= 1'b0;
      ts.ts_start <= 1'b0;
      ts.ts_end <= 1'b0;
      ts.ts_data <= '0;
      for (int i = 0; i < N_CH; i++) cc[i] <= '0;
    end else begin
      case (state)
        IDLE: if (enable && |ch_enable) state <= ARB;
        ARB: begin
          if (enable && gnt_vld) begin
            state <= SEND;
            idx <= '0;
            cur_ch <= gnt_idx;
            cur_pid <= pid[TS_PID_W*gnt_idx +: TS_PID_W];
            cur_cc <= cc[gnt_idx];
            cur_mode <= payload_mode;
            ts.ts_valid <= 1'b1;
            ts.ts_start <= 1'b1;
            ts.ts_end <= 1'b0;
            ts.ts_data <= TS_SYNC_BYTE;
          end else state <= IDLE;
        end
        SEND: begin
          if (ts.ts_ready) begin
            if (last_byte) begin
              ts.ts_valid <= 1'b0;
              ts.ts_start <= 1'b0;
              ts.ts_end <= 1'b0;
              ts.ts_data <= '0;
              cc[cur_ch] <= cur_cc + 1'b1;
              pkt_count <= pkt_count + 1'b1;
              ptr <= cur_ch;
              gap_cnt <= gap;
              state <= gap != 16'd0 ? GAP : ARB;
            end else begin
              idx <= nidx;
              ts.ts_data <= ts_byte(16'(nidx), cur_pid, cur_cc, cur_mode);
              ts.ts_start <= 1'b0;
              ts.ts_end <= nidx == IDX_W'(PKT_LEN - 1);
            end
          end
        end
        GAP: begin
          if (gap_cnt == 16'd1) state <= enable ? ARB : IDLE;
          else gap_cnt <= gap_cnt - 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ts_packet_gen_mc.sv
// tb_ts_packet_gen_mc: scoreboard bench for the multi-channel TS generator
module tb_ts_packet_gen_mc;
  localparam int N_CH = 4;
  localparam int PKT_LEN = 188;
  localparam int CH_W = 2;
  typedef struct {
    logic [7:0] d;
    logic s;
    logic e;
    logic [CH_W-1:0] ch;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic enable = 1'b0;
  logic payload_mode = 1'b0;
  logic [N_CH-1:0] ch_enable = '0;
  logic [13*N_CH-1:0] pid = '0;
  logic [15:0] gap = '0;
  logic [31:0] pkt_count;
  ts_packet_gen_mc_if #(.CH_W(CH_W)) ts ();
  ts_packet_gen_mc #(.N_CH(N_CH), .PKT_LEN(PKT_LEN)) dut (
    .clk(clk), .rst(rst), .enable(enable), .ch_enable(ch_enable), .pid(pid),
    .gap(gap), .payload_mode(payload_mode), .ts(ts), .pkt_count(pkt_count)
  );
  always #4 clk = ~clk;
  exp_t sb[$];
  int checks = 0;
  int passed = 0;
  logic [3:0] cc_m [N_CH];
  int n_start = 0;
  int n_end = 0;
  int byte_cnt = 0;
  longint cyc = 0;
  longint last_end_cyc = -1;
  longint exp_space = 0;
  bit bp = 1'b0;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act === req) passed++;
    else $display("FAIL %s: got %0h, required %0h", name, act, req);
  endtask
  task automatic timeout(input string name);
    checks++;
    $display("FAIL %s: wait expired, got no event, required event", name);
  endtask
  task automatic push_pkt(input int c, input bit mode);
    logic [12:0] p;
    exp_t x;
    p = pid[13*c +: 13];
    for (int i = 0; i < PKT_LEN; i++) begin
      x.s = i == 0;
      x.e = i == PKT_LEN - 1;
      x.ch = CH_W'(c);
      if (i == 0) x.d = 8'h47;
      else if (i == 1) x.d = 8'h40 | {3'b000, p[12:8]};
      else if (i == 2) x.d = p[7:0];
      else if (i == 3) x.d = 8'h10 | {4'h0, cc_m[c]};
      else x.d = mode ? 8'hFF : 8'((i - 4) % 256);
      sb.push_back(x);
    end
    cc_m[c] = cc_m[c] + 4'd1;
  endtask
  task automatic do_reset();
    rst = 1'b1;
    enable = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    for (int c = 0; c < N_CH; c++) cc_m[c] = 4'd0;
    sb.delete();
    last_end_cyc = -1;
  endtask
  task automatic run(input int npk, input int idle, input bit twiddle);
    int s0 = n_start;
    int e0 = n_end;
    int k = 0;
    enable = 1'b1;
    while (n_start < s0 + npk && k < npk * (idle + 800) + 100) begin
      @(posedge clk); #1; k++;
    end
    if (n_start < s0 + npk) timeout("start_timeout");
    enable = 1'b0;
    if (twiddle) begin
      pid[12:0] = 13'h1FFF;
      payload_mode = 1'b1;
      ch_enable = 4'b0010;
    end
    k = 0;
    while (n_end < e0 + npk && k < 1000) begin
      @(posedge clk); #1; k++;
    end
    if (n_end < e0 + npk) timeout("end_timeout");
    repeat (idle + 20) @(posedge clk);
    #1;
    chk("sb_drained", 64'(sb.size()), 64'd0);
    chk("idle_after_disable", 64'(ts.ts_valid), 64'd0);
  endtask
  initial forever begin
    @(posedge clk);
    #1 ts.ts_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
  end
  initial begin
    exp_t x;
    bit hold = 1'b0;
    logic [7:0] h_d;
    logic h_s, h_e;
    logic [CH_W-1:0] h_ch;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        hold = 1'b0;
        continue;
      end
      if (hold) chk("stall_hold", {ts.ts_valid, ts.ts_start, ts.ts_end, ts.ts_ch, ts.ts_data},
                    {1'b1, h_s, h_e, h_ch, h_d});
      hold = 1'b0;
      if (ts.ts_valid && ts.ts_ready) begin
        if (sb.size() == 0) begin
          checks++;
          $display("FAIL unexpected_byte: got data %0h ch %0d, required no byte", ts.ts_data, ts.ts_ch);
        end else begin
          x = sb.pop_front();
          chk("byte", {ts.ts_start, ts.ts_end, ts.ts_ch, ts.ts_data}, {x.s, x.e, x.ch, x.d});
        end
        if (ts.ts_start) begin
          n_start++;
          byte_cnt = 0;
          if (exp_space > 0 && last_end_cyc >= 0) chk("spacing", 64'(cyc - last_end_cyc), 64'(exp_space));
        end
        byte_cnt++;
        if (ts.ts_end) begin
          n_end++;
          last_end_cyc = cyc;
        end
      end else if (ts.ts_valid) begin
        hold = 1'b1;
        h_d = ts.ts_data;
        h_s = ts.ts_start;
        h_e = ts.ts_end;
        h_ch = ts.ts_ch;
      end
    end
  end
  initial begin
    int s0, k;
    do_reset();
    chk("rst_valid", 64'(ts.ts_valid), 64'd0);
    chk("rst_data", 64'(ts.ts_data), 64'd0);
    chk("rst_start_end", {ts.ts_start, ts.ts_end}, 64'd0);
    chk("rst_ch", 64'(ts.ts_ch), 64'd0);
    chk("rst_pkt_count", 64'(pkt_count), 64'd0);
    // single channel, back-to-back, in-flight packet unaffected by input changes
    ch_enable = 4'b0001; pid[12:0] = 13'h100; gap = 16'd0; payload_mode = 1'b0; exp_space = 2;
    push_pkt(0, 0); push_pkt(0, 0);
    run(2, 0, 1'b1);
    chk("single_pkt_count", 64'(pkt_count), 64'd2);
    // round-robin over channels 0,1,3
    do_reset();
    ch_enable = 4'b1011; payload_mode = 1'b0;
    for (int c = 0; c < N_CH; c++) pid[13*c +: 13] = 13'(16 + c);
    for (int r = 0; r < 2; r++) begin push_pkt(0, 0); push_pkt(1, 0); push_pkt(3, 0); end
    run(6, 0, 1'b0);
    chk("rr_pkt_count", 64'(pkt_count), 64'd6);
    // continuity counter wrap on channel 2
    do_reset();
    ch_enable = 4'b0100; pid[26 +: 13] = 13'h1ABC;
    for (int r = 0; r < 17; r++) push_pkt(2, 0);
    run(17, 0, 1'b0);
    chk("wrap_pkt_count", 64'(pkt_count), 64'd17);
    // random backpressure
    do_reset();
    ch_enable = 4'b0011; exp_space = 0; bp = 1'b1;
    push_pkt(0, 0); push_pkt(1, 0); push_pkt(0, 0);
    run(3, 0, 1'b0);
    bp = 1'b0;
    chk("bp_pkt_count", 64'(pkt_count), 64'd3);
    // long gap, null payload, enable dropped mid-packet
    do_reset();
    ch_enable = 4'b0001; gap = 16'd1000; payload_mode = 1'b1; exp_space = 1002;
    push_pkt(0, 1); push_pkt(0, 1);
    run(2, 1000, 1'b0);
    chk("gap_pkt_count", 64'(pkt_count), 64'd2);
    // asynchronous reset in the middle of a packet
    do_reset();
    ch_enable = 4'b1111; gap = 16'd0; payload_mode = 1'b0; exp_space = 2;
    push_pkt(0, 0); push_pkt(1, 0);
    s0 = n_start; k = 0;
    enable = 1'b1;
    while (!(n_start >= s0 + 2 && byte_cnt >= 51) && k < 2000) begin
      @(posedge clk); #1; k++;
    end
    if (!(n_start >= s0 + 2 && byte_cnt >= 51)) timeout("byte50_timeout");
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", 64'(ts.ts_valid), 64'd0);
    chk("arst_data", 64'(ts.ts_data), 64'd0);
    chk("arst_start_end", {ts.ts_start, ts.ts_end}, 64'd0);
    chk("arst_ch", 64'(ts.ts_ch), 64'd0);
    chk("arst_pkt_count", 64'(pkt_count), 64'd0);
    for (int c = 0; c < N_CH; c++) cc_m[c] = 4'd0;
    sb.delete();
    last_end_cyc = -1;
    @(posedge clk); @(posedge clk);
    #1 rst = 1'b0;
    push_pkt(0, 0);
    run(1, 0, 1'b0);
    chk("post_rst_pkt_count", 64'(pkt_count), 64'd1);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
